// File: rtl/decode_pkg.sv
// Shared RV32 decode definitions: opcodes, control encodings and the decoded control bundle.
// Imported by the decoder and the registered decode stage.
package decode_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;
    localparam logic [6:0] F7_MULD = 7'h01;

    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_S     = 3'b001,
        IMM_B     = 3'b010,
        IMM_U     = 3'b011,
        IMM_J     = 3'b100,
        IMM_SHAMT = 3'b101,
        IMM_R     = 3'b110,
        IMM_BU    = 3'b111
    } imm_src_e;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_BR   = 2'b01,
        ALU_OP   = 2'b10,
        ALU_PASS = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       reg_wr_en;
        logic       mem_wr_en;
        logic       alu_src;
        logic       alu_src_a_sel;
        logic       branch;
        logic       jump;
        logic       result_src;
        logic       is_signed;
        logic       is_muldiv;
        logic       illegal;
        imm_src_e   imm_src;
        alu_op_e    alu_op;
        logic [3:0] byte_en;
    } ctrl_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// Signal directions are named from the decode stage's point of view.
interface decode_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      instr_i;
    logic [XLEN-1:0]  pc_i;
    logic             flush_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [XLEN-1:0]  pc_o;
    logic [4:0]       rd_o;
    logic [4:0]       rs1_o;
    logic [4:0]       rs2_o;
    logic             reg_wr_en_o;
    logic             mem_wr_en_o;
    logic             alu_src_o;
    logic             alu_src_a_sel_o;
    logic             branch_o;
    logic             jump_o;
    logic             result_src_o;
    logic             signed_o;
    logic             is_muldiv_o;
    logic             illegal_o;
    logic [2:0]       imm_src_o;
    logic [1:0]       alu_op_o;
    logic [3:0]       byte_en_o;
    logic [CNT_W-1:0] illegal_cnt_o;

    modport master (
        output in_valid_i, instr_i, pc_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, pc_o, rd_o, rs1_o, rs2_o,
               reg_wr_en_o, mem_wr_en_o, alu_src_o, alu_src_a_sel_o, branch_o, jump_o,
               result_src_o, signed_o, is_muldiv_o, illegal_o, imm_src_o, alu_op_o,
               byte_en_o, illegal_cnt_o
    );

    modport slave (
        input  in_valid_i, instr_i, pc_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, pc_o, rd_o, rs1_o, rs2_o,
               reg_wr_en_o, mem_wr_en_o, alu_src_o, alu_src_a_sel_o, branch_o, jump_o,
               result_src_o, signed_o, is_muldiv_o, illegal_o, imm_src_o, alu_op_o,
               byte_en_o, illegal_cnt_o
    );
endinterface

// File: rtl/rv32_ctrl_decode.sv
// Combinational RV32I(+M) main decoder: instruction word to control bundle, with illegal detection.
// Zero latency; no flow control of its own.
module rv32_ctrl_decode
    import decode_pkg::*;
#(
    parameter bit EN_M_EXT = 1'b0
) (
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o
);

    logic [6:0] w_opcode;
    logic [6:0] w_funct7;
    logic [2:0] w_funct3;
    ctrl_t      w_c;

    assign w_opcode = instr_i[6:0];
    assign w_funct3 = instr_i[14:12];
    assign w_funct7 = instr_i[31:25];

    always_comb begin
        w_c     = '0;
        w_c.rd  = instr_i[11:7];
        w_c.rs1 = instr_i[19:15];
        w_c.rs2 = instr_i[24:20];
        case (w_opcode)
            OPC_LOAD: begin
                w_c.reg_wr_en  = 1'b1;
                w_c.alu_src    = 1'b1;
                w_c.result_src = 1'b1;
                w_c.imm_src    = IMM_I;
                case (w_funct3)
                    3'd0:    begin w_c.byte_en = 4'b0001; w_c.is_signed = 1'b1; end
                    3'd1:    begin w_c.byte_en = 4'b0011; w_c.is_signed = 1'b1; end
                    3'd2:    begin w_c.byte_en = 4'b1111; w_c.is_signed = 1'b1; end
                    3'd4:    w_c.byte_en = 4'b0001;
                    3'd5:    w_c.byte_en = 4'b0011;
                    default: w_c.illegal = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                w_c.reg_wr_en = 1'b1;
                w_c.alu_src   = 1'b1;
                w_c.is_signed = 1'b1;
                if (w_funct3 == 3'd1) begin
                    w_c.imm_src = IMM_SHAMT;
                    w_c.illegal = (w_funct7 != F7_BASE);
                end else if (w_funct3 == 3'd5) begin
                    w_c.imm_src = IMM_SHAMT;
                    // SRLI is the logical shift; SRAI keeps the sign
                    if (w_funct7 == F7_BASE) w_c.is_signed = 1'b0;
                    else if (w_funct7 != F7_ALT) w_c.illegal = 1'b1;
                end
            end
            OPC_STORE: begin
                w_c.mem_wr_en = 1'b1;
                w_c.alu_src   = 1'b1;
                w_c.alu_op    = ALU_PASS;
                w_c.imm_src   = IMM_S;
                case (w_funct3)
                    3'd0:    w_c.byte_en = 4'b0001;
                    3'd1:    w_c.byte_en = 4'b0011;
                    3'd2:    w_c.byte_en = 4'b1111;
                    default: w_c.illegal = 1'b1;
                endcase
            end
            OPC_OP: begin
                w_c.reg_wr_en = 1'b1;
                w_c.alu_op    = ALU_OP;
                w_c.imm_src   = IMM_R;
                case (w_funct7)
                    F7_BASE: ;
                    F7_ALT:  w_c.illegal = !((w_funct3 == 3'd0) || (w_funct3 == 3'd5));
                    F7_MULD: begin
                        if (EN_M_EXT) w_c.is_muldiv = 1'b1;
                        else          w_c.illegal   = 1'b1;
                    end
                    default: w_c.illegal = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                w_c.branch  = 1'b1;
                w_c.alu_op  = ALU_BR;
                w_c.imm_src = (w_funct3[2:1] == 2'b11) ? IMM_BU : IMM_B;
                w_c.illegal = (w_funct3[2:1] == 2'b01);
            end
            OPC_JAL, OPC_JALR: begin
                w_c.branch     = 1'b1;
                w_c.jump       = 1'b1;
                w_c.reg_wr_en  = 1'b1;
                w_c.alu_src    = 1'b1;
                w_c.result_src = 1'b1;
                if (w_opcode == OPC_JAL) begin
                    w_c.alu_op        = ALU_PASS;
                    w_c.imm_src       = IMM_J;
                    w_c.alu_src_a_sel = 1'b1;
                end else begin
                    w_c.alu_op  = ALU_ADD;
                    w_c.imm_src = IMM_I;
                    w_c.illegal = (w_funct3 != 3'd0);
                end
            end
            OPC_LUI, OPC_AUIPC: begin
                w_c.reg_wr_en     = 1'b1;
                w_c.alu_src       = 1'b1;
                w_c.imm_src       = IMM_U;
                w_c.alu_op        = ALU_PASS;
                w_c.alu_src_a_sel = 1'b1;
            end
            default: w_c.illegal = 1'b1;
        endcase
        // Illegal entries still flow downstream to raise a trap, but must not change state
        if (w_c.illegal) begin
            w_c.reg_wr_en = 1'b0;
            w_c.mem_wr_en = 1'b0;
            w_c.branch    = 1'b0;
            w_c.jump      = 1'b0;
        end
    end

    assign ctrl_o = w_c;

endmodule

// File: rtl/decode_stage.sv
// Registered RV32 decode stage: decoder feeding a DEPTH-entry FIFO of {pc, ctrl}; 1-cycle latency.
// in_ready_o comes from occupancy only (no path from out_ready_i); flush empties the FIFO next edge.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit EN_M_EXT = 1'b0,
    parameter int DEPTH    = 2,
    parameter int CNT_W    = 16
) (
    input logic           clk,
    input logic           rst,
    decode_stage_if.slave bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    ctrl_t            w_dec;
    ctrl_t            w_head;
    logic [XLEN-1:0]  w_head_pc;
    logic             w_push;
    logic             w_pop;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;
    logic [CNT_W-1:0] r_illegal_cnt;
    logic [XLEN-1:0]  r_pc_mem   [DEPTH];
    ctrl_t            r_ctrl_mem [DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    rv32_ctrl_decode #(.EN_M_EXT(EN_M_EXT)) u_dec (
        .instr_i (bus.instr_i),
        .ctrl_o  (w_dec)
    );

    assign bus.in_ready_o  = (r_occ < OCC_W'(DEPTH));
    assign bus.out_valid_o = (r_occ != '0);
    assign w_push = bus.in_valid_i & bus.in_ready_o & ~bus.flush_i;
    assign w_pop  = bus.out_valid_o & bus.out_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_occ         <= '0;
            r_illegal_cnt <= '0;
        end else begin
            if (bus.flush_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_occ    <= '0;
            end else begin
                if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
                if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
                if (w_push && !w_pop)      r_occ <= r_occ + 1'b1;
                else if (!w_push && w_pop) r_occ <= r_occ - 1'b1;
            end
            if (w_push && w_dec.illegal && (r_illegal_cnt != '1))
                r_illegal_cnt <= r_illegal_cnt + 1'b1;
        end
    end

    // Storage needs no reset: it is only observed through the valid-gated head
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= bus.pc_i;
            r_ctrl_mem[r_wr_ptr] <= w_dec;
        end
    end

    always_comb begin
        w_head    = '0;
        w_head_pc = '0;
        if (bus.out_valid_o) begin
            w_head    = r_ctrl_mem[r_rd_ptr];
            w_head_pc = r_pc_mem[r_rd_ptr];
        end
    end

    assign bus.pc_o            = w_head_pc;
    assign bus.rd_o            = w_head.rd;
    assign bus.rs1_o           = w_head.rs1;
    assign bus.rs2_o           = w_head.rs2;
    assign bus.reg_wr_en_o     = w_head.reg_wr_en;
    assign bus.mem_wr_en_o     = w_head.mem_wr_en;
    assign bus.alu_src_o       = w_head.alu_src;
    assign bus.alu_src_a_sel_o = w_head.alu_src_a_sel;
    assign bus.branch_o        = w_head.branch;
    assign bus.jump_o          = w_head.jump;
    assign bus.result_src_o    = w_head.result_src;
    assign bus.signed_o        = w_head.is_signed;
    assign bus.is_muldiv_o     = w_head.is_muldiv;
    assign bus.illegal_o       = w_head.illegal;
    assign bus.imm_src_o       = w_head.imm_src;
    assign bus.alu_op_o        = w_head.alu_op;
    assign bus.byte_en_o       = w_head.byte_en;
    assign bus.illegal_cnt_o   = r_illegal_cnt;

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, flow-controlled RV32 decode stage that generalises the combinational main decoder. It decodes a fetched instruction into the control bundle, flags illegal encodings, and optionally decodes the M extension. The decoded bundle is held in a small skid FIFO so that fetch and execute are decoupled by a valid/ready handshake. It sits between the fetch register and the execute stage and supports pipeline flush.

## Interface
- `XLEN`, 32: width of `pc_i`/`pc_o`.
- `EN_M_EXT`, 0: 1 enables decode of OP with funct7=0x01 (MUL/DIV family).
- `DEPTH`, 2: FIFO entries. Legal range is ≥2.
- `CNT_W`, 16: width of the illegal-instruction counter.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid_i`  in  1  fetch offers an instruction.
- `in_ready_o`  out  1  stage accepts this cycle.
- `instr_i`  in  32  instruction word.
- `pc_i`  in  XLEN  instruction PC.
- `flush_i`  in  1  discard all buffered entries.
- `out_valid_o`  out  1  head entry valid.
- `out_ready_i`  in  1  execute consumes head.
- `pc_o`  out  XLEN  PC of head.
- `rd_o`, `rs1_o`, `rs2_o`  out  5 each  register fields of head.
- `reg_wr_en_o`, `mem_wr_en_o`, `alu_src_o`, `alu_src_a_sel_o`, `branch_o`, `jump_o`, `result_src_o`, `signed_o`, `is_muldiv_o`, `illegal_o`  out  1 each  control bits of head.
- `imm_src_o`  out  3  immediate-source control of head.
- `alu_op_o`  out  2  ALU-op control of head.
- `byte_en_o`  out  4  byte enables of head.
- `illegal_cnt_o`  out  CNT_W  saturating count of illegal instructions accepted.

## Operation
- **Decode (combinational on input).**
  - imm_src encodings: I=000, S=001, B=010, U=011, J=100, shamt=101, R=110, B-unsigned=111.
  - LOAD 0000011: reg_wr=1, alu_src=1, result_src=1, imm_src=000. byte_en/signed by funct3: 0→0001/1, 1→0011/1, 2→1111/1, 4→0001/0, 5→0011/0.
  - OP-IMM 0010011: reg_wr=1, alu_src=1, signed=1. funct3 1/5 use imm_src=101; SRLI (funct7=0) sets signed=0.
  - STORE 0100011: mem_wr=1, alu_src=1, alu_op=11, imm_src=001. byte_en 0001/0011/1111 for funct3 0/1/2.
  - OP 0110011: reg_wr=1, alu_op=10, imm_src=110. is_muldiv=1 when funct7=0x01 and EN_M_EXT=1.
  - BRANCH 1100011: branch=1, alu_op=01. imm_src=111 for funct3 6/7, otherwise 010.
  - JAL 1101111: branch=jump=1, reg_wr=1, alu_src=1, result_src=1, alu_op=11, imm_src=100, alu_src_a_sel=1.
  - JALR 1100111: same as JAL but imm_src=000, alu_op=00, alu_src_a_sel=0.
  - LUI 0110111 / AUIPC 0010111: reg_wr=1, alu_src=1, imm_src=011, alu_op=11, alu_src_a_sel=1.
  - Every bit not listed above is 0.
- **Illegal encodings:**
  - unknown opcode;
  - LOAD funct3 ∈ {3,6,7};
  - STORE funct3 > 2;
  - BRANCH funct3 ∈ {2,3};
  - JALR funct3 ≠ 0;
  - OP funct7 ∉ {0x00, 0x20 (funct3 0/5 only), 0x01 (only when EN_M_EXT)};
  - OP-IMM shift with bad funct7.
- **Illegal handling:** the entry is still enqueued with illegal=1 and reg_wr, mem_wr, branch, jump forced to 0, so a trap is raised downstream. illegal_cnt increments on acceptance and saturates at all-ones.
- **FIFO behaviour:**
  - Push when in_valid_i & in_ready_o; pop when out_valid_o & out_ready_i. Simultaneous push and pop leaves the occupancy unchanged.
  - in_ready_o = (occupancy < DEPTH). It depends on registered state only and has no combinational path from out_ready_i.
  - out_valid_o = (occupancy ≠ 0).
  - When out_valid_o = 0, all head outputs read 0.
- **Flush:**
  - On the next edge, occupancy becomes 0.
  - A push in the flush cycle is dropped and is not counted.
  - The illegal counter is not cleared.

## Timing
- Latency: an accepted instruction appears at the outputs on the cycle after acceptance (1 cycle).
- Throughput: 1 instruction per cycle at steady state with DEPTH ≥ 2.
- Reset values: occupancy 0, out_valid_o=0, in_ready_o=1, all control outputs 0, illegal_cnt_o=0, pointers 0.
- Reset mid-operation clears everything asynchronously.
- Pointers wrap modulo DEPTH. DEPTH need not be a power of two.
- When full with out_ready_i=1: the pop happens, but in_ready_o stays 0 that cycle and rises the next cycle.

## Structure
- Package `decode_pkg`:
  - opcode localparams;
  - imm_src and alu_op encodings;
  - packed struct `ctrl_t` holding all control fields plus rd/rs1/rs2/illegal.
- Sub-module `rv32_ctrl_decode`: combinational, `instr_i` → `ctrl_t`, parameter EN_M_EXT.
- `decode_stage` contains the FIFO of {pc, ctrl_t}, the occupancy counter, the pointers and the illegal counter.

## Test plan
- Push 0x00500093 (ADDI x1,x0,5) with out_ready=1. Next cycle: out_valid=1, reg_wr=1, alu_src=1, imm_src=000, signed=1, rd=1.
- Push 0x0000A103 (LW x2,0(x1)) → result_src=1, byte_en=1111, signed=1, rs1=1, rd=2.
- Push 0x022081B3 (MUL):
  - with EN_M_EXT=1 → is_muldiv=1, alu_op=10, illegal=0;
  - with EN_M_EXT=0 → illegal=1, reg_wr=0, illegal_cnt=1.
- Push 0xFFFFFFFF → illegal=1, all enables 0. Repeated until the counter reaches 2^CNT_W−1, it saturates there.
- Hold out_ready=0 and push 2 instructions → in_ready=0 after the second. A third offer is not accepted. Release → entries come out in order A, B.
- Fill the FIFO, then assert flush_i together with in_valid_i → the next cycle shows out_valid=0, occupancy 0, and the offered instruction is lost.
